// File: rtl/spi_cmd_sequencer.sv
// Command front end for the SPI engine: takes one flash descriptor, pushes header
// (and write payload) into the TX FIFO, launches the engine and reports done/err.
module spi_cmd_sequencer #(
  parameter int DATA         = 8,
  parameter int MAX_BYTES    = 256,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [7:0]      cmd_opcode,
  input  logic [15:0]     cmd_addr,
  input  logic [15:0]     cmd_nbytes,
  input  logic            cmd_write,
  input  logic [DATA-1:0] pl_data,
  input  logic            pl_valid,
  output logic            pl_ready,
  output logic [DATA-1:0] fifo_wdata,
  output logic            fifo_wr,
  input  logic            fifo_full,
  output logic [15:0]     spi_len,
  output logic            spi_op,
  output logic            spi_work,
  input  logic            spi_busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    HDR       = 3'd2,
    PAYLOAD   = 3'd3,
    START     = 3'd4,
    WAIT_BUSY = 3'd5,
    WAIT_DONE = 3'd6,
    FINISH    = 3'd7
  } state_e;

  localparam logic [15:0] MAX_B    = 16'(MAX_BYTES);
  localparam logic [15:0] TMO_LOAD = 16'(BUSY_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] nbytes_q, nbytes_d;
  logic        write_q, write_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] spi_len_q, spi_len_d;
  logic        spi_op_q, spi_op_d;
  logic        spi_work_q, spi_work_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opcode_q   <= 8'd0;
      addr_q     <= 16'd0;
      nbytes_q   <= 16'd0;
      write_q    <= 1'b0;
      idx_q      <= 2'd0;
      cnt_q      <= 16'd0;
      tmo_q      <= 16'd0;
      spi_len_q  <= 16'd0;
      spi_op_q   <= 1'b0;
      spi_work_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      addr_q     <= addr_d;
      nbytes_q   <= nbytes_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      spi_len_q  <= spi_len_d;
      spi_op_q   <= spi_op_d;
      spi_work_q <= spi_work_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    addr_d    = addr_q;
    nbytes_d  = nbytes_q;
    write_d   = write_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    spi_len_d = spi_len_q;
    spi_op_d  = spi_op_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          opcode_d = cmd_opcode;
          addr_d   = cmd_addr;
          nbytes_d = cmd_nbytes;
          write_d  = cmd_write;
          state_d  = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if ((nbytes_q == 16'd0) || (nbytes_q > MAX_B)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          spi_len_d = {nbytes_q[12:0] + 13'd3, 3'b000};
          spi_op_d  = write_q;
          idx_d     = 2'd0;
          cnt_d     = 16'd0;
          state_d   = HDR;
        end
      end
      HDR: begin
        // The timeout counter is loaded on the way into START and counts START itself.
        if (!fifo_full) begin
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            tmo_d   = TMO_LOAD;
            state_d = write_q ? PAYLOAD : START;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          state_d = HDR;
        end
      end
      PAYLOAD: begin
        if (pl_valid && !fifo_full) begin
          cnt_d = cnt_q + 16'd1;
          if ((cnt_q + 16'd1) == nbytes_q) begin
            tmo_d   = TMO_LOAD;
            state_d = START;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end
      START: begin
        tmo_d   = tmo_q - 16'd1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q <= 16'd1) begin
          tmo_d   = 16'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy) begin
          state_d = FINISH;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    spi_work_d = (state_d == START);
    done_d     = (state_d == FINISH);
  end

  // Combinational handshakes and FIFO write path
  always_comb begin
    cmd_ready  = 1'b0;
    pl_ready   = 1'b0;
    fifo_wr    = 1'b0;
    fifo_wdata = pl_data;
    case (state_q)
      IDLE: cmd_ready = ~rst;
      HDR: begin
        fifo_wr = ~rst & ~fifo_full;
        case (idx_q)
          2'd0:    fifo_wdata = opcode_q;
          2'd1:    fifo_wdata = addr_q[15:8];
          default: fifo_wdata = addr_q[7:0];
        endcase
      end
      PAYLOAD: begin
        pl_ready = ~rst & ~fifo_full;
        fifo_wr  = ~rst & pl_valid & ~fifo_full;
      end
      default: fifo_wr = 1'b0;
    endcase
  end

  assign spi_len  = spi_len_q;
  assign spi_op   = spi_op_q;
  assign spi_work = spi_work_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: directed and randomized descriptors checked against a
// transaction-level model of the expected FIFO byte stream, launch and completion timing.
module tb_spi_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode = 8'd0;
  logic [15:0] cmd_addr = 16'd0;
  logic [15:0] cmd_nbytes = 16'd0;
  logic        cmd_write = 1'b0;
  logic [7:0]  pl_data = 8'd0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [7:0]  fifo_wdata;
  logic        fifo_wr;
  logic        fifo_full = 1'b0;
  logic [15:0] spi_len;
  logic        spi_op;
  logic        spi_work;
  logic        spi_busy = 1'b0;
  logic        done;
  logic        err;

  localparam int MAXB = 256;
  localparam int TMO  = 16;

  spi_cmd_sequencer #(.DATA(8), .MAX_BYTES(MAXB), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes), .cmd_write(cmd_write),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .fifo_wdata(fifo_wdata), .fifo_wr(fifo_wr), .fifo_full(fifo_full),
    .spi_len(spi_len), .spi_op(spi_op), .spi_work(spi_work), .spi_busy(spi_busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  // stimulus knobs
  int cyc = 0;
  logic rst_req = 1'b1;
  logic want_cmd = 1'b0, hold_valid = 1'b0, eng_en = 1'b1;
  int bp_pct = 0, plv_pct = 100, fs_lo = -1, fs_hi = -1;
  logic [7:0]  c_op;
  logic [15:0] c_addr, c_n;
  logic        c_wr;
  logic [7:0]  pl_q[$];
  int pl_idx = 0;

  // observations
  logic [7:0] wr_q[$];
  int wr_first, wr_last, acc_cnt, acc_cyc, work_cnt, work_cyc, done_cnt, done_cyc;
  int err_cnt, err_cyc, busy_left, busy_fall;
  logic [15:0] work_len, len_at_done;
  logic work_op, rdy2, rst_comb_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL txn%0d %s: observed %0h expected %0h", txn_id, tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    wr_q.delete();
    wr_first = -1; wr_last = -1; acc_cnt = 0; acc_cyc = -10;
    work_cnt = 0; work_cyc = -1; done_cnt = 0; done_cyc = -1;
    err_cnt = 0; err_cyc = -1; busy_left = 0; busy_fall = -1;
    work_len = 16'd0; len_at_done = 16'd0; work_op = 1'b0;
    rdy2 = 1'b0; rst_comb_seen = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, observe what the next rising edge will take.
  task automatic cycle();
    logic ended_now;
    @(negedge clk);
    rst = rst_req;
    if (busy_left > 0) begin
      spi_busy = 1'b1;
      busy_left--;
    end else begin
      if (spi_busy) busy_fall = cyc;
      spi_busy = 1'b0;
    end
    if (spi_work === 1'b1) begin
      work_cnt++; work_cyc = cyc; work_len = spi_len; work_op = spi_op;
      if (eng_en) busy_left = int'(spi_len);
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; len_at_done = spi_len; end
    if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    ended_now = (done === 1'b1) || (err === 1'b1);
    fifo_full = ((cyc >= fs_lo) && (cyc < fs_hi)) ||
                ((bp_pct > 0) && ($urandom_range(99) < bp_pct));
    pl_valid = (pl_idx < pl_q.size()) && ($urandom_range(99) < plv_pct);
    pl_data  = pl_valid ? pl_q[pl_idx] : 8'($urandom);
    cmd_valid  = want_cmd && !ended_now;
    cmd_opcode = c_op; cmd_addr = c_addr; cmd_nbytes = c_n; cmd_write = c_wr;
    #1;
    if (rst && (fifo_wr || pl_ready || cmd_ready)) rst_comb_seen = 1'b1;
    if (fifo_wr) begin
      wr_q.push_back(fifo_wdata);
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
    end
    if (pl_valid && pl_ready) pl_idx++;
    if (cmd_valid && cmd_ready) begin
      acc_cnt++; acc_cyc = cyc;
      if (!hold_valid) want_cmd = 1'b0;
    end
    if ((acc_cnt == 1) && (cyc == acc_cyc + 2)) rdy2 = cmd_ready;
    cyc++;
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [15:0] addr, input logic [15:0] n,
                         input logic wr, input int bp, input int plv, input logic eng,
                         input int fs_off, input logic hold);
    logic legal, ended;
    int nexp, explen;
    logic [7:0] exp_q[$];
    txn_id++;
    clear_rec();
    legal = (n != 16'd0) && (int'(n) <= MAXB);
    c_op = op; c_addr = addr; c_n = n; c_wr = wr;
    pl_q.delete(); pl_idx = 0;
    if (wr && legal) for (int i = 0; i < int'(n); i++) pl_q.push_back(8'($urandom));
    bp_pct = bp; plv_pct = plv; eng_en = eng; fs_lo = -1; fs_hi = -1;
    hold_valid = hold; want_cmd = 1'b1;
    ended = 1'b0;
    for (int i = 0; i < 3000 && !ended; i++) begin
      cycle();
      if ((acc_cnt == 1) && (fs_off >= 0) && (fs_lo < 0)) begin
        fs_lo = acc_cyc + fs_off; fs_hi = fs_lo + 3;
      end
      ended = (done_cnt + err_cnt) > 0;
    end
    want_cmd = 1'b0; bp_pct = 0; fs_lo = -1; fs_hi = -1;
    repeat (3) cycle();
    chk("txn_completed", ended, 1'b1);
    chk("accept_count", acc_cnt, 1);
    // expected byte stream: opcode, address high, address low, then payload
    exp_q.delete();
    if (legal) begin
      exp_q.push_back(op); exp_q.push_back(addr[15:8]); exp_q.push_back(addr[7:0]);
      foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
    end
    nexp = exp_q.size();
    chk("fifo_write_count", wr_q.size(), nexp);
    for (int i = 0; i < nexp && i < wr_q.size(); i++) chk("fifo_byte", wr_q[i], exp_q[i]);
    chk("ready_2_after_accept", rdy2, !legal);
    if (!legal) begin
      chk("illegal_err_count", err_cnt, 1);
      chk("illegal_no_work", work_cnt, 0);
      chk("illegal_no_done", done_cnt, 0);
      chk("illegal_err_timing", (err_cyc >= acc_cyc + 1) && (err_cyc <= acc_cyc + 2), 1'b1);
    end else begin
      explen = 8 * (3 + int'(n));
      chk("work_count", work_cnt, 1);
      chk("spi_len", work_len, explen);
      chk("spi_op", work_op, wr);
      chk("first_write_not_early", wr_first >= acc_cyc + 2, 1'b1);
      chk("work_after_last_byte", work_cyc, wr_last + 1);
      if (wr) chk("payload_consumed", pl_idx, int'(n));
      if ((bp == 0) && (plv == 100) && (fs_off < 0))
        chk("launch_latency", work_cyc - acc_cyc, 5 + (wr ? int'(n) : 0));
      if (eng) begin
        chk("done_count", done_cnt, 1);
        chk("no_err", err_cnt, 0);
        chk("done_after_busy_fall", done_cyc, busy_fall + 1);
        chk("len_stable_at_done", len_at_done, explen);
      end else begin
        chk("timeout_err_count", err_cnt, 1);
        chk("timeout_no_done", done_cnt, 0);
        chk("timeout_err_timing", err_cyc - work_cyc, TMO);
      end
    end
  endtask

  initial begin
    clear_rec();
    rst_req = 1'b1;
    repeat (3) cycle();
    chk("reset_comb_outputs_low", rst_comb_seen, 1'b0);
    rst_req = 1'b0;
    cycle();
    chk("reset_spi_len", spi_len, 16'd0);
    chk("reset_spi_op", spi_op, 1'b0);
    chk("reset_pulses", {spi_work, done, err}, 3'b000);
    chk("reset_cmd_ready", cmd_ready, 1'b1);

    // directed: read, write, header/payload backpressure, illegal sizes, timeout, max size
    run_txn(8'h03, 16'h1234, 16'd4, 1'b0, 0, 100, 1'b1, -1, 1'b0);
    run_txn(8'h02, 16'h00A0, 16'd2, 1'b1, 0, 100, 1'b1, -1, 1'b0);
    run_txn(8'h02, 16'h5A5A, 16'd5, 1'b1, 0, 50, 1'b1, 3, 1'b1);
    run_txn(8'h0B, 16'h4000, 16'd0, 1'b0, 0, 100, 1'b1, -1, 1'b0);
    run_txn(8'h02, 16'h4000, 16'd257, 1'b1, 0, 100, 1'b1, -1, 1'b1);
    run_txn(8'h03, 16'hBEEF, 16'd1, 1'b0, 0, 100, 1'b0, -1, 1'b0);
    run_txn(8'h02, 16'hFFFF, 16'd256, 1'b1, 0, 100, 1'b1, -1, 1'b0);

    // randomized descriptors with random FIFO backpressure and payload gaps
    for (int k = 0; k < 12; k++)
      run_txn(8'($urandom), 16'($urandom), 16'($urandom_range(8, 1)), 1'($urandom),
              $urandom_range(40, 0), $urandom_range(100, 50), 1'b1, -1, 1'($urandom));

    // reset while in the payload phase after one of two bytes
    txn_id++;
    clear_rec();
    c_op = 8'h9F; c_addr = 16'h0102; c_n = 16'd2; c_wr = 1'b1;
    pl_q.delete(); pl_q.push_back(8'h11); pl_q.push_back(8'h22); pl_idx = 0;
    bp_pct = 0; plv_pct = 100; eng_en = 1'b1; fs_lo = -1; fs_hi = -1;
    hold_valid = 1'b0; want_cmd = 1'b1;
    for (int i = 0; i < 40 && pl_idx < 1; i++) cycle();
    chk("rst_test_reached_payload", pl_idx, 1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    chk("rst_comb_forced_low", rst_comb_seen, 1'b0);
    chk("rst_writes_before", wr_q.size(), 4);
    repeat (5) cycle();
    chk("rst_no_more_writes", wr_q.size(), 4);
    chk("rst_payload_not_taken", pl_idx, 1);
    chk("rst_no_pulses", work_cnt + done_cnt + err_cnt, 0);
    chk("rst_spi_len", spi_len, 16'd0);
    chk("rst_spi_op", spi_op, 1'b0);
    chk("rst_idle_ready", cmd_ready, 1'b1);
    pl_q.delete(); pl_idx = 0;
    run_txn(8'h03, 16'h0077, 16'd3, 1'b0, 0, 100, 1'b1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Command front end for the SPI engine. It accepts one flash transaction descriptor (opcode, 16-bit address, byte count, direction) over a valid/ready handshake.
- It pushes the 3-byte header into the engine's TX FIFO. For writes it then streams the payload bytes into the same FIFO.
- It then launches the engine with `work`/`len`/`op`, tracks `busy` to completion, and reports `done` or `err`.
- Read data returns through the engine's RX FIFO, not through this block.

Parameters:
- DATA, 8, FIFO byte width; fixed at 8.
- MAX_BYTES, 256, largest legal cmd_nbytes; must be ≤ 8188 so that len fits in 16 bits.
- BUSY_TIMEOUT, 16, cycles allowed between the work pulse and spi_busy rising.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  descriptor accepted when high together with cmd_valid
- cmd_opcode  in  8  flash opcode
- cmd_addr  in  16  flash address
- cmd_nbytes  in  16  payload/read byte count
- cmd_write  in  1  1 = write transaction, 0 = read transaction
- pl_data  in  DATA  write payload byte
- pl_valid  in  1  payload valid
- pl_ready  out  1  payload accept
- fifo_wdata  out  DATA  TX FIFO write data
- fifo_wr  out  1  TX FIFO write strobe
- fifo_full  in  1  TX FIFO full
- spi_len  out  16  transaction length in bits
- spi_op  out  1  1 = write-only, 0 = header then read
- spi_work  out  1  one-cycle start pulse to the engine
- spi_busy  in  1  engine busy
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse

Behaviour:

Reset values:
- All registered outputs are 0: spi_len, spi_op, spi_work, done, err.
- State is IDLE.
- cmd_ready, pl_ready and fifo_wr are forced to 0 while rst is high.
- A reset mid-transaction aborts immediately. No further FIFO writes occur, and no done or err pulse is issued.

States: IDLE, CHECK, HDR, PAYLOAD, START, WAIT_BUSY, WAIT_DONE, FINISH.

- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch opcode, addr, nbytes and write; go to CHECK.
- CHECK:
  - If nbytes == 0 or nbytes > MAX_BYTES: err = 1 for one cycle, go to IDLE. The FIFO is untouched.
  - Otherwise: register spi_len = 8*(3+nbytes) (16-bit) and spi_op = write; clear the byte index; go to HDR.
- HDR:
  - fifo_wr = ~fifo_full (combinational).
  - fifo_wdata is selected by index: 0 = opcode, 1 = addr[15:8], 2 = addr[7:0].
  - The index advances only on an actual write.
  - After byte 2: go to PAYLOAD if write, else START.
- PAYLOAD:
  - pl_ready = ~fifo_full.
  - fifo_wr = pl_valid & pl_ready; fifo_wdata = pl_data.
  - A 16-bit byte counter increments on each write. When it reaches nbytes, go to START.
  - Stalls on fifo_full or ~pl_valid are unbounded.
- START:
  - spi_work = 1 for exactly one cycle.
  - Load the timeout counter with BUSY_TIMEOUT; go to WAIT_BUSY.
- WAIT_BUSY:
  - spi_busy = 1: go to WAIT_DONE.
  - Timeout counter reaches 0: err pulse, go to IDLE.
- WAIT_DONE:
  - spi_busy = 0: go to FINISH.
  - No timeout applies in this state.
- FINISH:
  - done = 1 for one cycle; go to IDLE.

Rules across states:
- spi_len and spi_op stay stable from CHECK until the next accepted descriptor.
- Outside HDR and PAYLOAD: fifo_wr = 0 and pl_ready = 0.
- Latency from an accepted command to the work pulse is 5 cycles for a read with no backpressure (one cycle each in CHECK and START, three in HDR), plus nbytes cycles for a write.
- cmd_valid asserted while not in IDLE is ignored (not accepted).
- A fifo_full rise in the same cycle as a pending write blocks that write; the byte is retried the next cycle.

Test Plan:
1. Read: opcode 0x03, addr 0x1234, nbytes 4, write 0, FIFO never full → FIFO writes 0x03, 0x12, 0x34 on consecutive cycles. spi_work pulses with spi_len = 56 and spi_op = 0. The engine model raises busy for 56 cycles; done pulses one cycle after busy falls.
2. Write: opcode 0x02, addr 0x00A0, nbytes 2, payload 0xDE, 0xAD → FIFO sequence is 0x02, 0x00, 0xA0, 0xDE, 0xAD. spi_len = 40, spi_op = 1, then done.
3. Backpressure: fifo_full held high for 3 cycles mid-header, and pl_valid toggled during the payload → no writes while full; byte order is preserved; spi_len is unchanged.
4. Illegal descriptors: nbytes = 0, then nbytes = 257 → each produces an err pulse; no fifo_wr and no spi_work. cmd_ready returns high 2 cycles after acceptance.
5. Timeout: spi_busy never rises → err pulses BUSY_TIMEOUT cycles after spi_work; the block returns to IDLE.
6. Reset during PAYLOAD after 1 of 2 bytes → all outputs go to 0, state returns to IDLE, and there is no done or err. A subsequent read command completes normally.
